// File: rtl/sa_feeder.sv
// Systolic-array operand feeder: streams one tile of buffer words and skews
// lane r by r extra register stages so operand waves enter the array diagonally.

// One skew lane: DEPTH register stages of data plus a matching valid shift register.
// Invalid slots carry zero so the downstream PE accumulators stay unchanged.
module sa_feeder_lane #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_vld,
  output logic [DATA_SIZE-1:0] out_data
);
  localparam int STAGES = DEPTH - 1;

  logic [STAGES:0][DATA_SIZE-1:0] dat_pipe;
  logic [STAGES:0]                vld_pipe;

  // Shift data/valid down the lane; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      dat_pipe[0] <= in_vld ? in_data : '0;
      vld_pipe[0] <= in_vld;
      for (int i = 1; i <= STAGES; i++) begin
        dat_pipe[i] <= dat_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign out_data = dat_pipe[STAGES];
  assign out_vld  = vld_pipe[STAGES];
endmodule

module sa_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [7:0]                     k_len,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] rd_data,
  output logic                           pe_clr,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] a_out,
  output logic [ARRAY_SIZE-1:0]          a_valid
);
  // Drain long enough for the deepest lane to empty with margin.
  localparam int DRAIN_LEN = 2 * ARRAY_SIZE;
  localparam int CNT_W     = ($clog2(DRAIN_LEN) > 8) ? $clog2(DRAIN_LEN) : 8;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         k_q;
  logic               rd_vld;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Phase counter restarts on every state change; tile parameters latch on accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      k_q    <= '0;
      rd_vld <= 1'b0;
    end else begin
      cnt    <= (state != state_n) ? '0 : cnt + 1'b1;
      rd_vld <= rd_en;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        k_q    <= k_len;
      end else if (state == FEED) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_n = state;
    busy    = 1'b1;
    done    = 1'b0;
    pe_clr  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = (k_len == 8'd0) ? DONE : CLEAR;
      end
      CLEAR: begin
        pe_clr  = 1'b1;
        state_n = FEED;
      end
      FEED: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        if (cnt == CNT_W'(k_q - 8'd1)) state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt == CNT_W'(DRAIN_LEN - 1)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane r gets r+1 stages after the rd_vld-aligned capture point.
  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
    sa_feeder_lane #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (r + 1)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (rd_vld),
      .in_data  (rd_data[r*DATA_SIZE +: DATA_SIZE]),
      .out_vld  (a_valid[r]),
      .out_data (a_out[r*DATA_SIZE +: DATA_SIZE])
    );
  end
endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder: per-cycle expectations from a cycle-index model.
module tb_sa_feeder;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [7:0]      k_len;
  logic            busy, done, rd_en, pe_clr;
  logic [AW-1:0]   rd_addr;
  logic [N*D-1:0]  rd_data;
  logic [N*D-1:0]  a_out;
  logic [N-1:0]    a_valid;

  logic [AW-1:0]   tb_base;
  int              n_asrt = 0;
  int              n_fail = 0;

  sa_feeder #(.ARRAY_SIZE(N), .DATA_SIZE(D), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pe_clr    (pe_clr),
    .a_out     (a_out),
    .a_valid   (a_valid)
  );

  always #5 clk = ~clk;

  // Word i of a tile: lane r = 4i+r.
  function automatic logic [N*D-1:0] mkword(input logic [AW-1:0] i);
    logic [N*D-1:0] w;
    for (int r = 0; r < N; r++) w[r*D +: D] = D'(4 * int'(i) + r);
    return w;
  endfunction

  // Registered buffer: data one cycle after rd_en, garbage otherwise.
  always @(posedge clk)
    rd_data <= rd_en ? mkword(rd_addr - tb_base) : {N{8'hA5}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},    64'(busy),    64'd0);
    chk({tag, ".done"},    64'(done),    64'd0);
    chk({tag, ".rd_en"},   64'(rd_en),   64'd0);
    chk({tag, ".rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, ".pe_clr"},  64'(pe_clr),  64'd0);
    chk({tag, ".a_out"},   64'(a_out),   64'd0);
    chk({tag, ".a_valid"}, 64'(a_valid), 64'd0);
  endtask

  // Start one tile in the current (idle) cycle and check every cycle through
  // the idle cycle following done. extra_t>0 re-pulses start at that cycle.
  task automatic run_tile(input string tag, input logic [AW-1:0] base,
                          input logic [7:0] k, input int extra_t);
    int            done_t, rd_seen, done_seen, c;
    logic          e_rd;
    logic [AW-1:0] e_addr;
    logic [N*D-1:0] e_out;
    logic [N-1:0]  e_vld;
    tb_base   = base;
    base_addr = base;
    k_len     = k;
    start     = 1'b1;
    rd_seen   = 0;
    done_seen = 0;
    done_t    = (k == 8'd0) ? 1 : int'(k) + 2 * N + 2;
    for (int t = 1; t <= done_t + 1; t++) begin
      tick();
      start  = (t == extra_t);
      e_rd   = (k != 8'd0) && (t >= 2) && (t <= int'(k) + 1);
      e_addr = e_rd ? base + AW'(t - 2) : '0;
      e_out  = '0;
      e_vld  = '0;
      for (int r = 0; r < N; r++) begin
        c = t - 2 - r;
        if (k != 8'd0 && c >= 2 && c <= int'(k) + 1) begin
          e_vld[r]        = 1'b1;
          e_out[r*D +: D] = D'(4 * (c - 2) + r);
        end
      end
      chk({tag, ".busy"},    64'(busy),    64'(t <= done_t));
      chk({tag, ".done"},    64'(done),    64'(t == done_t));
      chk({tag, ".pe_clr"},  64'(pe_clr),  64'(t == 1 && k != 8'd0));
      chk({tag, ".rd_en"},   64'(rd_en),   64'(e_rd));
      chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(e_addr));
      chk({tag, ".a_out"},   64'(a_out),   64'(e_out));
      chk({tag, ".a_valid"}, 64'(a_valid), 64'(e_vld));
      rd_seen   += int'(rd_en);
      done_seen += int'(done);
    end
    start = 1'b0;
    chk({tag, ".rd_count"},   64'(rd_seen),   64'(k));
    chk({tag, ".done_count"}, 64'(done_seen), 64'd1);
  endtask

  initial begin
    int done_seen;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    k_len     = '0;
    tb_base   = '0;
    tick();
    tick();
    chk_idle("reset");

    // Reset wins over start in the same cycle.
    start = 1'b1;
    k_len = 8'd3;
    tick();
    chk_idle("rst_prio");
    start = 1'b0;
    rst   = 1'b0;
    tick();
    chk_idle("post_rst");

    run_tile("basic", 10'h010, 8'd3, 0);
    run_tile("zero",  10'h000, 8'd0, 0);
    run_tile("wrap",  10'h3FE, 8'd4, 0);
    run_tile("busy_start", 10'h100, 8'd3, 3);
    run_tile("b2b_a", 10'h050, 8'd2, 0);
    run_tile("b2b_b", 10'h060, 8'd3, 0);

    // Mid-tile reset in the second FEED cycle.
    tb_base   = 10'h020;
    base_addr = 10'h020;
    k_len     = 8'd5;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst.pe_clr", 64'(pe_clr), 64'd1);
    tick();
    chk("midrst.feed1", 64'(rd_addr), 64'h020);
    tick();
    chk("midrst.feed2", 64'(rd_addr), 64'h021);
    rst = 1'b1;
    tick();
    chk_idle("midrst.after");
    rst       = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3 * N + 4; i++) begin
      tick();
      done_seen += int'(done);
      chk("midrst.quiet_busy", 64'(busy), 64'd0);
    end
    chk("midrst.no_done", 64'(done_seen), 64'd0);
    run_tile("after_rst", 10'h040, 8'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
